// File: rtl/parameters_pkg.sv
// Shared field parameters for the EdDSA (Ed448) core.
package parameters_pkg;
  localparam int DATA_WIDTH = 448;
endpackage

// File: rtl/mul_mont_arbiter.sv
// Round-robin arbiter sharing one mul_mont Montgomery multiplier among NUM_REQ requesters.
// Grants in IDLE, pulses start, waits for done, returns the result with a one-hot pulse.
module mul_mont_arbiter
  import parameters_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy,
  output logic [31:0]                   op_count,
  output logic                          mm_start,
  output logic [DATA_WIDTH-1:0]         mm_a,
  output logic [DATA_WIDTH-1:0]         mm_b,
  input  logic [DATA_WIDTH-1:0]         mm_result,
  input  logic                          mm_done
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [1:0] S_FLUSH = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] flush_cnt;
  logic [IW-1:0] last_grant, cur, gnt, idx;
  logic          any_req, hs;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] a_lane, b_lane;
  assign a_lane = req_a;
  assign b_lane = req_b;

  // Walk from farthest to nearest candidate so the nearest one after last_grant wins.
  always_comb begin
    gnt     = last_grant;
    idx     = '0;
    any_req = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        gnt     = idx;
        any_req = 1'b1;
      end
    end
  end

  assign hs = (state == S_IDLE) && any_req;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[gnt] = 1'b1;
  end

  assign mm_start = (state == S_ISSUE);
  assign busy     = (state != S_IDLE);

  // mul_mont itself has no reset; the FLUSH window outlasts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FLUSH;
      flush_cnt  <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      cur        <= '0;
      mm_a       <= '0;
      mm_b       <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      op_count   <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        S_FLUSH: begin
          if (flush_cnt == CW'(FLUSH_CYCLES - 1)) state <= S_IDLE;
          else flush_cnt <= flush_cnt + CW'(1);
        end
        S_IDLE: begin
          if (hs) begin
            mm_a       <= a_lane[gnt];
            mm_b       <= b_lane[gnt];
            last_grant <= gnt;
            cur        <= gnt;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (mm_done) begin
            rsp_data       <= mm_result;
            rsp_valid[cur] <= 1'b1;
            op_count       <= op_count + 32'd1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_FLUSH;
      endcase
    end
  end
endmodule
